keymem: RTL and testbench



---
 rtl/keymem_pkg.sv | 23 ++
 rtl/keymem_ram.sv | 39 +++
 rtl/keymem.sv | 220 ++++++++++++++++++++++
 tb/tb_keymem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keymem_pkg.sv
// Shared sizes and FSM encoding for the key memory.
package keymem_pkg;

    localparam int KEY_W         = 256;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_KEY = 8;
    localparam int NUM_KEYS      = 1024;
    localparam int ADDR_W        = 15;
    localparam int RAM_AW        = 13;
    localparam int RAM_DEPTH     = 1 << RAM_AW;
    localparam int KEY_IDX_W     = 10;

    // Fetch timer: loaded on request, ack at terminal count 1.
    localparam logic [3:0] FETCH_CNT_LOAD = 4'd10;
    // Word reads are issued while the timer is at or above this value.
    localparam logic [3:0] FETCH_CNT_RDMIN = 4'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } key_state_e;

endpackage

// File: rtl/keymem_ram.sv
// True dual-port 8192x32 RAM: port A read/write with byte enables, port B
// read-only. Both ports have one cycle of read latency. A port-A write and a
// port-B read of the same word in one cycle return the old word on port B.
module keymem_ram
    import keymem_pkg::*;
(
    input  logic              clk,
    input  logic              a_en,
    input  logic [3:0]        a_we,
    input  logic [RAM_AW-1:0] a_addr,
    input  logic [WORD_W-1:0] a_wdata,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [RAM_AW-1:0] b_addr,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] mem_q [RAM_DEPTH] = '{default: '0};

    // Port A: byte-enabled write plus registered read.
    always_ff @(posedge clk) begin
        if (a_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_we[i]) begin
                    mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
            a_rdata <= mem_q[a_addr];
        end
    end

    // Port B: registered read of the pre-write contents.
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem_q[b_addr];
        end
    end

endmodule

// File: rtl/keymem.sv
// Key memory: AXI4-Lite slave for loading keys and a fetch FSM that
// assembles a 256-bit key from eight consecutive RAM words.
//
// state | meaning
// IDLE  | waiting for key_req
// FETCH | timer running; 8 word reads, shift-in, then key_ack
module keymem
    import keymem_pkg::*;
(
    input  logic              s_axi_clk,
    input  logic              s_axi_reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [WORD_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [WORD_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              key_req,
    input  logic [31:0]       key_id,
    output logic              key_ack,
    output logic [KEY_W-1:0]  key
);

    logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [RAM_AW-1:0] awaddr_q, awaddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic              ar_busy_q, ar_busy_d, rd_issue_q, rd_issue_d;
    logic              rd_dly_q, rd_dly_d, rvalid_q, rvalid_d;
    logic [RAM_AW-1:0] araddr_q, araddr_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    key_state_e           state_q, state_d;
    logic [KEY_IDX_W-1:0] id_q, id_d;
    logic                 id_bad_q, id_bad_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rdb_vld_q, rdb_vld_d;
    logic                 ack_q, ack_d;
    logic [KEY_W-1:0]     key_q, key_d;

    logic              aw_take, w_take, ar_take, we_a, rd_go, rd_cycle;
    logic [3:0]        word_idx;
    logic [WORD_W-1:0] a_rdata, b_rdata;
    logic              unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = !s_axi_reset && !aw_full_q && !bvalid_q;
    assign s_axi_wready  = !s_axi_reset && !w_full_q && !bvalid_q;
    assign s_axi_arready = !s_axi_reset && !ar_busy_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = rdata_q;
    assign key_ack       = ack_q;
    assign key           = key_q;

    assign aw_take  = s_axi_awvalid && s_axi_awready;
    assign w_take   = s_axi_wvalid && s_axi_wready;
    assign ar_take  = s_axi_arvalid && s_axi_arready;
    assign we_a     = aw_full_q && w_full_q;
    // Port A is shared; a pending read waits one cycle behind a write.
    assign rd_go    = rd_issue_q && !we_a;
    assign rd_cycle = (state_q == FETCH) && (cnt_q >= FETCH_CNT_RDMIN);
    assign word_idx = FETCH_CNT_LOAD - cnt_q;

    // Write channel: capture AW and W independently, write once both are held.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        if (we_a) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_take) begin
            aw_full_d = 1'b1;
            awaddr_d  = s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_take) begin
            w_full_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        // B rises together with the RAM write cycle.
        if (!we_a && (aw_full_q || aw_take) && (w_full_q || w_take)) bvalid_d = 1'b1;
    end

    // Read channel: address register, RAM cycle, output register.
    always_comb begin
        ar_busy_d  = ar_busy_q;
        araddr_d   = araddr_q;
        rd_issue_d = rd_issue_q;
        rd_dly_d   = rd_go;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        if (ar_take) begin
            ar_busy_d  = 1'b1;
            araddr_d   = s_axi_araddr[ADDR_W-1:2];
            rd_issue_d = 1'b1;
        end else if (rd_go) begin
            rd_issue_d = 1'b0;
        end
        if (rvalid_q && s_axi_rready) begin
            rvalid_d  = 1'b0;
            ar_busy_d = 1'b0;
        end
        if (rd_dly_q) begin
            rvalid_d = 1'b1;
            rdata_d  = a_rdata;
        end
    end

    // Key fetch FSM with down-counting timer.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        id_bad_d  = id_bad_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        rdb_vld_d = rd_cycle;
        key_d     = key_q;
        if (rdb_vld_q) key_d = {key_q[KEY_W-WORD_W-1:0], id_bad_q ? '0 : b_rdata};
        case (state_q)
            IDLE: begin
                if (key_req) begin
                    state_d  = FETCH;
                    id_d     = key_id[KEY_IDX_W-1:0];
                    id_bad_d = |key_id[31:KEY_IDX_W];
                    cnt_d    = FETCH_CNT_LOAD;
                end
            end
            FETCH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset never touches the RAM.
    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            ar_busy_q  <= 1'b0;
            araddr_q   <= '0;
            rd_issue_q <= 1'b0;
            rd_dly_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            state_q    <= IDLE;
            id_q       <= '0;
            id_bad_q   <= 1'b0;
            cnt_q      <= '0;
            rdb_vld_q  <= 1'b0;
            ack_q      <= 1'b0;
            key_q      <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            ar_busy_q  <= ar_busy_d;
            araddr_q   <= araddr_d;
            rd_issue_q <= rd_issue_d;
            rd_dly_q   <= rd_dly_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            id_q       <= id_d;
            id_bad_q   <= id_bad_d;
            cnt_q      <= cnt_d;
            rdb_vld_q  <= rdb_vld_d;
            ack_q      <= ack_d;
            key_q      <= key_d;
        end
    end

    keymem_ram u_ram (
        .clk     (s_axi_clk),
        .a_en    (we_a || rd_go),
        .a_we    (we_a ? wstrb_q : 4'b0000),
        .a_addr  (we_a ? awaddr_q : araddr_q),
        .a_wdata (wdata_q),
        .a_rdata (a_rdata),
        .b_en    (rd_cycle && !id_bad_q),
        .b_addr  ({id_q, word_idx[2:0]}),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_keymem.sv
// Directed bench for keymem: AXI4-Lite loads and reads, key fetch latency,
// out-of-range IDs, ignored requests during FETCH, and reset mid-fetch.
module tb_keymem;

    logic         s_axi_clk = 1'b0;
    logic         s_axi_reset = 1'b1;
    logic [14:0]  s_axi_awaddr = '0;
    logic [2:0]   s_axi_awprot = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [14:0]  s_axi_araddr = '0;
    logic [2:0]   s_axi_arprot = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic         key_req = 1'b0;
    logic [31:0]  key_id = '0;
    logic         key_ack;
    logic [255:0] key;

    int checks = 0;
    int errors = 0;

    always #5 s_axi_clk = ~s_axi_clk;

    keymem dut (
        .s_axi_clk     (s_axi_clk),
        .s_axi_reset   (s_axi_reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .key_req       (key_req),
        .key_id        (key_id),
        .key_ack       (key_ack),
        .key           (key)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge s_axi_clk);
        #1;
    endtask

    task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        int n;
        bit aw_done, w_done, a_hs, w_hs;
        n = 0;
        aw_done = 1'b0;
        w_done = 1'b0;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        while (!(aw_done && w_done) && n < 50) begin
            s_axi_awvalid = !aw_done && (n >= aw_dly);
            s_axi_wvalid  = !w_done && (n >= w_dly);
            a_hs = s_axi_awvalid && s_axi_awready;
            w_hs = s_axi_wvalid && s_axi_wready;
            step();
            n++;
            if (a_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("wr_accept", 256'(aw_done && w_done), 256'd1);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            step();
            n++;
        end
        chk("bvalid", 256'(s_axi_bvalid), 256'd1);
        chk("bresp", 256'(s_axi_bresp), 256'd0);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [14:0] a, output logic [31:0] d);
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        while (!hs && n < 50) begin
            hs = s_axi_arready;
            step();
            n++;
        end
        s_axi_arvalid = 1'b0;
        chk("ar_accept", 256'(hs), 256'd1);
        chk("arready_low", 256'(s_axi_arready), 256'd0);
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            step();
            n++;
        end
        chk("rd_latency", 256'(n), 256'd2);
        chk("rresp", 256'(s_axi_rresp), 256'd0);
        d = s_axi_rdata;
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        chk("arready_back", 256'(s_axi_arready), 256'd1);
    endtask

    // Returns cycles from the sampling edge to the visible ack (30 = none).
    task automatic fetch(input logic [31:0] id, input int poke, output int lat, output logic [255:0] k);
        int n;
        key_req = 1'b1;
        key_id  = id;
        step();
        key_req = 1'b0;
        n = 0;
        while (!key_ack && n < 30) begin
            key_req = (n == poke);
            step();
            n++;
        end
        key_req = 1'b0;
        lat = n;
        k = key;
    endtask

    logic [31:0]  rd;
    logic [255:0] k;
    int           lat;
    int           acks;

    initial begin
        repeat (2) step();
        chk("rst_awready", 256'(s_axi_awready), 256'd0);
        chk("rst_wready", 256'(s_axi_wready), 256'd0);
        chk("rst_arready", 256'(s_axi_arready), 256'd0);
        s_axi_reset = 1'b0;
        step();
        chk("idle_awready", 256'(s_axi_awready), 256'd1);
        chk("idle_wready", 256'(s_axi_wready), 256'd1);
        chk("idle_arready", 256'(s_axi_arready), 256'd1);
        chk("rst_bvalid", 256'(s_axi_bvalid), 256'd0);
        chk("rst_rvalid", 256'(s_axi_rvalid), 256'd0);
        chk("rst_rdata", 256'(s_axi_rdata), 256'd0);
        chk("rst_key_ack", 256'(key_ack), 256'd0);
        chk("rst_key", key, 256'd0);

        axi_read(15'h100, rd);
        chk("rd_100_init", 256'(rd), 256'h0);

        axi_write(15'h100, 32'h5555_5555, 4'hF, 0, 0);
        axi_read(15'h100, rd);
        chk("rd_100_a", 256'(rd), 256'h5555_5555);

        fetch(32'd8, -1, lat, k);
        chk("f8_lat", 256'(lat), 256'd10);
        chk("f8_key", k, {32'h5555_5555, 224'h0});
        step();
        chk("f8_ack_1cyc", 256'(key_ack), 256'd0);
        chk("f8_key_hold", key, {32'h5555_5555, 224'h0});

        // AW leads W by three cycles
        axi_write(15'h104, 32'hFFFF_FFFF, 4'h3, 0, 3);
        axi_read(15'h104, rd);
        chk("rd_104", 256'(rd), 256'h0000_FFFF);

        fetch(32'd8, -1, lat, k);
        chk("f8b_key", k, {32'h5555_5555, 32'h0000_FFFF, 192'h0});

        // W leads AW; last word of the last valid key
        axi_write(15'h7FFC, 32'h1234_5678, 4'hF, 2, 0);
        fetch(32'd1023, -1, lat, k);
        chk("f1023_lat", 256'(lat), 256'd10);
        chk("f1023_key", k, {224'h0, 32'h1234_5678});

        fetch(32'h400, 3, lat, k);
        chk("f400_lat", 256'(lat), 256'd10);
        chk("f400_key", k, 256'd0);
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (key_ack) acks++;
        end
        chk("f400_no_2nd_ack", 256'(acks), 256'd0);

        key_req = 1'b1;
        key_id  = 32'd8;
        step();
        key_req = 1'b0;
        repeat (4) step();
        s_axi_reset = 1'b1;
        step();
        s_axi_reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            if (key_ack) acks++;
            step();
        end
        chk("rstfetch_no_ack", 256'(acks), 256'd0);
        chk("rstfetch_key", key, 256'd0);
        axi_read(15'h100, rd);
        chk("rd_100_kept", 256'(rd), 256'h5555_5555);

        // Single byte lane, and low address bits ignored
        axi_write(15'h100, 32'hAABB_CCDD, 4'h4, 0, 0);
        axi_read(15'h100, rd);
        chk("rd_100_lane2", 256'(rd), 256'h55BB_5555);
        axi_write(15'h10B, 32'hCAFE_F00D, 4'hF, 0, 0);
        axi_read(15'h108, rd);
        chk("rd_108", 256'(rd), 256'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
